// File: rtl/univ_shftreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst FSM states and the shift-mode classifier.
package univ_shftreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_ZERO = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Modes that move bits one position; only these may start a burst.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shftreg_shft_next.sv
// Combinational next-value generator: given an operation and the current
// register contents, produce the value the register takes on the next edge.
module shft_next
  import univ_shftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] inp,
  input  logic             in_sr,
  input  logic             in_sl,
  output logic [WIDTH-1:0] d_next
);

  // Decode the operation into the next register value.
  always_comb begin
    d_next = d;
    case (mode)
      MODE_HOLD: d_next = d;
      MODE_SHR:  d_next = {in_sr, d[WIDTH-1:1]};
      MODE_SHL:  d_next = {d[WIDTH-2:0], in_sl};
      MODE_LOAD: d_next = inp;
      MODE_ROR:  d_next = {d[0], d[WIDTH-1:1]};
      MODE_ROL:  d_next = {d[WIDTH-2:0], d[WIDTH-1]};
      MODE_ASR:  d_next = {d[WIDTH-1], d[WIDTH-1:1]};
      MODE_ZERO: d_next = '0;
      default:   d_next = d;
    endcase
  end

endmodule

// File: rtl/univ_shftreg.sv
// Universal shift register with an autonomous WIDTH-shift burst engine.
// In IDLE the register follows MODE; a START with a shift mode latches that
// mode and runs exactly WIDTH shifts, then pulses DONE for one cycle.
module univ_shftreg
  import univ_shftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] InP,
  input  logic             InSR,
  input  logic             InSL,
  input  logic             START,
  output logic [WIDTH-1:0] D,
  output logic             OutSR,
  output logic             OutSL,
  output logic             BUSY,
  output logic             DONE
);

  // Burst counter must hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       burst_mode_q, burst_mode_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             done_q, done_d;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] d_next;

  // While a burst runs the latched mode drives the datapath, MODE is ignored.
  always_comb begin
    op_mode = MODE;
    if (state_q == ST_RUN) op_mode = burst_mode_q;
  end

  shft_next #(
    .WIDTH (WIDTH)
  ) u_shft_next (
    .mode   (op_mode),
    .d      (d_q),
    .inp    (InP),
    .in_sr  (InSR),
    .in_sl  (InSL),
    .d_next (d_next)
  );

  // Next-state, counter, burst-mode and data decode; DONE self-clears.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    burst_mode_d = burst_mode_q;
    d_d          = d_q;
    done_d       = 1'b0;
    if (EN) begin
      case (state_q)
        ST_IDLE: begin
          if (START && is_shift_mode(MODE)) begin
            // Accepting the burst is not itself a shift; D holds this edge.
            state_d      = ST_RUN;
            burst_mode_d = MODE;
            cnt_d        = CW'(WIDTH);
          end else begin
            d_d = d_next;
          end
        end
        ST_RUN: begin
          d_d   = d_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register; Clear aborts any burst without producing DONE.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      burst_mode_q <= MODE_HOLD;
      d_q          <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_mode_q <= burst_mode_d;
      d_q          <= d_d;
      done_q       <= done_d;
    end
  end

  assign D     = d_q;
  assign OutSR = d_q[0];
  assign OutSL = d_q[WIDTH-1];
  assign BUSY  = (state_q == ST_RUN);
  assign DONE  = done_q;

endmodule

// File: tb/tb_univ_shftreg.sv
// Bench for univ_shftreg: three widths (8, 2, 32) share one stimulus stream and
// are compared every cycle against an arithmetic reference model, with
// directed checks of the documented example values on top.
module tb_univ_shftreg;

  logic        CLK = 1'b0;
  logic        Clear, EN, InSR, InSL, START;
  logic [2:0]  MODE;
  logic [31:0] InP;

  logic [7:0]  D8;
  logic [1:0]  D2;
  logic [31:0] D32;
  logic        OutSR8, OutSL8, BUSY8, DONE8;
  logic        OutSR2, OutSL2, BUSY2, DONE2;
  logic        OutSR32, OutSL32, BUSY32, DONE32;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, one slot per instance (0: W=8, 1: W=2, 2: W=32).
  logic [31:0] m_d    [3];
  logic        m_busy [3];
  logic        m_done [3];
  int          m_left [3];
  logic [2:0]  m_bm   [3];

  always #5 CLK = ~CLK;

  univ_shftreg #(.WIDTH(8)) u8 (
    .CLK(CLK), .Clear(Clear), .EN(EN), .MODE(MODE), .InP(InP[7:0]),
    .InSR(InSR), .InSL(InSL), .START(START),
    .D(D8), .OutSR(OutSR8), .OutSL(OutSL8), .BUSY(BUSY8), .DONE(DONE8)
  );

  univ_shftreg #(.WIDTH(2)) u2 (
    .CLK(CLK), .Clear(Clear), .EN(EN), .MODE(MODE), .InP(InP[1:0]),
    .InSR(InSR), .InSL(InSL), .START(START),
    .D(D2), .OutSR(OutSR2), .OutSL(OutSL2), .BUSY(BUSY2), .DONE(DONE2)
  );

  univ_shftreg #(.WIDTH(32)) u32 (
    .CLK(CLK), .Clear(Clear), .EN(EN), .MODE(MODE), .InP(InP),
    .InSR(InSR), .InSL(InSL), .START(START),
    .D(D32), .OutSR(OutSR32), .OutSL(OutSL32), .BUSY(BUSY32), .DONE(DONE32)
  );

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 32;
  endfunction

  // Result of one operation, computed as plain integer arithmetic on w bits.
  function automatic logic [31:0] apply(input logic [2:0] m, input logic [31:0] d,
                                        input int w, input logic sr, input logic sl,
                                        input logic [31:0] p);
    logic [63:0] mask, x, r, top;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    top  = 64'd1 << (w - 1);
    case (m)
      3'd1:    r = (x >> 1) | (sr ? top : 64'd0);
      3'd2:    r = (x << 1) | {63'd0, sl};
      3'd3:    r = {32'd0, p};
      3'd4:    r = (x >> 1) | (((x & 64'd1) != 64'd0) ? top : 64'd0);
      3'd5:    r = (x << 1) | (x >> (w - 1));
      3'd6:    r = (x >> 1) | (x & top);
      3'd7:    r = 64'd0;
      default: r = x;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (Clear) begin
        m_d[i] = 32'd0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0;
      end else begin
        logic nd;
        nd = 1'b0;
        if (EN) begin
          if (m_busy[i]) begin
            m_d[i] = apply(m_bm[i], m_d[i], w_of(i), InSR, InSL, InP);
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
              m_busy[i] = 1'b0;
              nd = 1'b1;
            end
          end else if (START && (MODE inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
            m_bm[i] = MODE; m_left[i] = w_of(i); m_busy[i] = 1'b1;
          end else begin
            m_d[i] = apply(MODE, m_d[i], w_of(i), InSR, InSL, InP);
          end
        end
        m_done[i] = nd;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w8_D",     32'(D8),       m_d[0]);
    chk("w8_BUSY",  32'(BUSY8),    32'(m_busy[0]));
    chk("w8_DONE",  32'(DONE8),    32'(m_done[0]));
    chk("w8_OutSR", 32'(OutSR8),   32'(m_d[0][0]));
    chk("w8_OutSL", 32'(OutSL8),   32'(m_d[0][7]));
    chk("w2_D",     32'(D2),       m_d[1]);
    chk("w2_BUSY",  32'(BUSY2),    32'(m_busy[1]));
    chk("w2_DONE",  32'(DONE2),    32'(m_done[1]));
    chk("w2_OutSR", 32'(OutSR2),   32'(m_d[1][0]));
    chk("w2_OutSL", 32'(OutSL2),   32'(m_d[1][1]));
    chk("w32_D",    D32,           m_d[2]);
    chk("w32_BUSY", 32'(BUSY32),   32'(m_busy[2]));
    chk("w32_DONE", 32'(DONE32),   32'(m_done[2]));
    chk("w32_OutSR", 32'(OutSR32), 32'(m_d[2][0]));
    chk("w32_OutSL", 32'(OutSL32), 32'(m_d[2][31]));
  endtask

  // One clock: model and DUT both take the edge, outputs checked 1 ns later.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic load(input logic [31:0] v);
    MODE = 3'd3; InP = v; START = 1'b0;
    tick();
  endtask

  task automatic clear_pulse();
    Clear = 1'b1; START = 1'b0; MODE = 3'd0;
    tick();
    Clear = 1'b0;
  endtask

  initial begin
    logic [2:0] sw_mode [7];
    logic       sw_sr   [7];
    logic       sw_sl   [7];
    logic [7:0] sw_exp  [7];
    logic       bits    [8];

    for (int i = 0; i < 3; i++) begin
      m_d[i] = 32'd0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0; m_bm[i] = 3'd0;
    end
    Clear = 1'b1; EN = 1'b1; MODE = 3'd3; InP = 32'hA5; InSR = 1'b0; InSL = 1'b0; START = 1'b0;

    // Reset in the middle of a LOAD of A5.
    tick();
    chk("rst_D", 32'(D8), 32'h00);
    chk("rst_BUSY", 32'(BUSY8), 32'd0);
    chk("rst_DONE", 32'(DONE8), 32'd0);
    tick();
    Clear = 1'b0;

    // Mode sweep from 96.
    sw_mode = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    sw_sr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sw_sl   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sw_exp  = '{8'hCB, 8'h2D, 8'h4B, 8'h2D, 8'hCB, 8'h00, 8'h96};
    for (int k = 0; k < 7; k++) begin
      load(32'h96);
      MODE = sw_mode[k]; InSR = sw_sr[k]; InSL = sw_sl[k];
      tick();
      chk($sformatf("sweep_mode%0d", sw_mode[k]), 32'(D8), 32'(sw_exp[k]));
    end
    InSR = 1'b0; InSL = 1'b0;

    // ROL burst on 81, then a new START accepted in the DONE cycle.
    load(32'h81);
    MODE = 3'd5; START = 1'b1;
    tick();
    chk("rol_accept_BUSY", 32'(BUSY8), 32'd1);
    chk("rol_accept_D", 32'(D8), 32'h81);
    START = 1'b0; MODE = 3'd0;
    repeat (7) tick();
    chk("rol_edge7_BUSY", 32'(BUSY8), 32'd1);
    chk("rol_edge7_DONE", 32'(DONE8), 32'd0);
    tick();
    chk("rol_end_D", 32'(D8), 32'h81);
    chk("rol_end_BUSY", 32'(BUSY8), 32'd0);
    chk("rol_end_DONE", 32'(DONE8), 32'd1);
    MODE = 3'd5; START = 1'b1;
    tick();
    chk("rol_restart_BUSY", 32'(BUSY8), 32'd1);
    chk("rol_restart_DONE", 32'(DONE8), 32'd0);
    START = 1'b0; MODE = 3'd0;
    repeat (8) tick();
    chk("rol2_end_DONE", 32'(DONE8), 32'd1);
    clear_pulse();

    // SHR burst used as a deserializer, plain and with 3 EN-low cycles.
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int pass = 0; pass < 2; pass++) begin
      load(32'h0);
      MODE = 3'd1; START = 1'b1;
      tick();
      START = 1'b0; MODE = 3'd0;
      for (int k = 0; k < 8; k++) begin
        if (pass == 1 && k == 4) begin
          EN = 1'b0;
          for (int g = 0; g < 3; g++) begin
            InSR = 1'($urandom_range(0, 1));
            tick();
          end
          chk("deser_gap_BUSY", 32'(BUSY8), 32'd1);
          EN = 1'b1;
        end
        if (k == 7) chk($sformatf("deser%0d_pre_DONE", pass), 32'(DONE8), 32'd0);
        InSR = bits[k];
        tick();
      end
      chk($sformatf("deser%0d_D", pass), 32'(D8), 32'h4D);
      chk($sformatf("deser%0d_DONE", pass), 32'(DONE8), 32'd1);
      clear_pulse();
    end
    InSR = 1'b0;

    // START with LOAD is ignored as a burst request.
    MODE = 3'd3; InP = 32'h5A; START = 1'b1;
    tick();
    chk("start_load_D", 32'(D8), 32'h5A);
    chk("start_load_BUSY", 32'(BUSY8), 32'd0);

    // START during RUN does not restart the count.
    MODE = 3'd4; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    MODE = 3'd2; START = 1'b1;
    tick();
    START = 1'b0; MODE = 3'd0;
    repeat (3) tick();
    chk("run_start_pre_DONE", 32'(DONE8), 32'd0);
    tick();
    chk("run_start_DONE", 32'(DONE8), 32'd1);
    chk("run_start_D", 32'(D8), 32'h5A);
    clear_pulse();

    // Clear at shift 4 aborts the burst with no DONE.
    load(32'hF0);
    MODE = 3'd2; START = 1'b1; InSL = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    Clear = 1'b1;
    tick();
    chk("abort_D", 32'(D8), 32'h0);
    chk("abort_BUSY", 32'(BUSY8), 32'd0);
    chk("abort_DONE", 32'(DONE8), 32'd0);
    Clear = 1'b0; MODE = 3'd0; InSL = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_DONE", 32'(DONE8), 32'd0);
    end

    // ROL burst on the narrow and wide instances.
    load(32'h8000_0001);
    MODE = 3'd5; START = 1'b1;
    tick();
    START = 1'b0; MODE = 3'd0;
    repeat (2) tick();
    chk("w2_rol_D", 32'(D2), 32'h1);
    chk("w2_rol_DONE", 32'(DONE2), 32'd1);
    repeat (30) tick();
    chk("w32_rol_D", D32, 32'h8000_0001);
    chk("w32_rol_BUSY", 32'(BUSY32), 32'd0);
    chk("w32_rol_DONE", 32'(DONE32), 32'd1);
    tick();
    chk("w32_rol_DONE_clr", 32'(DONE32), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      Clear = ($urandom_range(0, 59) == 0);
      EN    = ($urandom_range(0, 4) != 0);
      MODE  = 3'($urandom_range(0, 7));
      START = ($urandom_range(0, 3) == 0);
      InP   = $urandom;
      InSR  = 1'($urandom_range(0, 1));
      InSL  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
